// File: rtl/par_tx_pkg.sv
// Shared types and line-level constants for the parity-framed serial transmitter.
package par_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/par_gen.sv
// Combinational even/odd parity generator for a DATA_W-bit word.
module par_gen #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] d,
    output logic              even,
    output logic              odd
);

    assign even = ^d;
    assign odd  = ~^d;

endmodule

// File: rtl/par_frame_tx.sv
// Serial transmitter: start, data LSB-first, parity, stop; each bit lasts CLKS_PER_BIT cycles.
// Optional macro PAR_TX_ERR_INJ_EN adds Err_Inj, which inverts the transmitted parity bit per frame.
module par_frame_tx
    import par_tx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] Data,
    input  logic              Odd_Sel,
    input  logic              Valid,
`ifdef PAR_TX_ERR_INJ_EN
    input  logic              Err_Inj,
`endif
    output logic              Ready,
    output logic              TxD,
    output logic              Busy,
    output logic              Even_Parity,
    output logic              Odd_Parity
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    state_t              state, state_nxt;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift;
    logic                odd_sel_q;
    logic                err_inj_q;
    logic                gen_even, gen_odd;
    logic                accept, baud_done, bit_done, par_bit;

    par_gen #(.DATA_W(DATA_W)) u_par_gen (
        .d    (Data),
        .even (gen_even),
        .odd  (gen_odd)
    );

    assign Ready     = (state == IDLE);
    assign Busy      = (state != IDLE);
    assign accept    = Valid & Ready;
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign bit_done  = (bit_cnt == BIT_LAST);

`ifdef PAR_TX_ERR_INJ_EN
    assign par_bit = (odd_sel_q ? Odd_Parity : Even_Parity) ^ err_inj_q;
`else
    assign par_bit = odd_sel_q ? Odd_Parity : Even_Parity;
    assign err_inj_q = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults assigned first so no path through the case leaves an output unassigned (no latch).
    always_comb begin
        state_nxt = state;
        TxD       = IDLE_LEVEL;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = START;
            end
            START: begin
                TxD = START_BIT;
                if (baud_done) state_nxt = DATA;
            end
            DATA: begin
                TxD = shift[0];
                if (baud_done && bit_done) state_nxt = PARITY;
            end
            PARITY: begin
                TxD = par_bit;
                if (baud_done) state_nxt = STOP;
            end
            STOP: begin
                TxD = STOP_BIT;
                if (baud_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame datapath: everything the frame needs is captured on accept, so later input changes are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            odd_sel_q   <= 1'b0;
            Even_Parity <= 1'b0;
            Odd_Parity  <= 1'b1;
        end else if (accept) begin
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= Data;
            odd_sel_q   <= Odd_Sel;
            Even_Parity <= gen_even;
            Odd_Parity  <= gen_odd;
        end else if (state != IDLE) begin
            if (baud_done) begin
                baud_cnt <= '0;
                if (state == DATA) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_done ? '0 : bit_cnt + 1'b1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

`ifdef PAR_TX_ERR_INJ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_inj_q <= 1'b0;
        else if (accept) err_inj_q <= Err_Inj;
    end
`endif

endmodule

// File: tb/tb_par_frame_tx.sv
// Directed bench for par_frame_tx: one instance at CLKS_PER_BIT=4 and one at CLKS_PER_BIT=1.
module tb_par_frame_tx;

    localparam int DATA_W = 4;
    localparam int NBITS  = DATA_W + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [DATA_W-1:0] data_a = '0, data_b = '0;
    logic odd_sel_a = 1'b0, odd_sel_b = 1'b0;
    logic valid_a = 1'b0, valid_b = 1'b0;
    logic ready_a, txd_a, busy_a, even_a, odd_a;
    logic ready_b, txd_b, busy_b, even_b, odd_b;
`ifdef PAR_TX_ERR_INJ_EN
    logic err_a = 1'b0, err_b = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    par_frame_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .Data(data_a), .Odd_Sel(odd_sel_a), .Valid(valid_a),
`ifdef PAR_TX_ERR_INJ_EN
        .Err_Inj(err_a),
`endif
        .Ready(ready_a), .TxD(txd_a), .Busy(busy_a), .Even_Parity(even_a), .Odd_Parity(odd_a)
    );

    par_frame_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .Data(data_b), .Odd_Sel(odd_sel_b), .Valid(valid_b),
`ifdef PAR_TX_ERR_INJ_EN
        .Err_Inj(err_b),
`endif
        .Ready(ready_b), .TxD(txd_b), .Busy(busy_b), .Even_Parity(even_b), .Odd_Parity(odd_b)
    );

    function automatic logic txd_of(input int sel);
        return (sel != 0) ? txd_b : txd_a;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic ready_of(input int sel);
        return (sel != 0) ? ready_b : ready_a;
    endfunction

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send(input int sel, input logic [DATA_W-1:0] d, input logic osel, input logic inj);
        int n = 0;
        while (ready_of(sel) !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout sel=%0d: Ready never rose within 200 cycles", sel);
        end
`ifdef PAR_TX_ERR_INJ_EN
        if (sel != 0) err_b = inj; else err_a = inj;
`endif
        if (sel != 0) begin data_b = d; odd_sel_b = osel; valid_b = 1'b1; end
        else          begin data_a = d; odd_sel_a = osel; valid_a = 1'b1; end
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    // Starts #1 after the accept edge: checks parity outputs, every line cycle, decoded word and the idle gap.
    task automatic check_frame(input int sel, input logic [DATA_W-1:0] d, input logic osel,
                               input logic inj, input string name);
        int cpb = (sel != 0) ? 1 : 4;
        logic exp_bits [NBITS];
        logic rx_bits [NBITS];
        logic [DATA_W-1:0] rx_data;
        logic exp_even = ^d;
        logic exp_odd = ~^d;
        logic got_even = (sel != 0) ? even_b : even_a;
        logic got_odd = (sel != 0) ? odd_b : odd_a;
        checks++;
        if (got_even !== exp_even || got_odd !== exp_odd) begin
            errors++;
            $display("FAIL %s parity_out: even=%b odd=%b expected even=%b odd=%b",
                     name, got_even, got_odd, exp_even, exp_odd);
        end
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) exp_bits[i+1] = d[i];
        exp_bits[DATA_W+1] = (osel ? exp_odd : exp_even) ^ inj;
        exp_bits[DATA_W+2] = 1'b1;
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                rx_bits[b] = txd_of(sel);
                checks++;
                if (txd_of(sel) !== exp_bits[b] || busy_of(sel) !== 1'b1) begin
                    errors++;
                    $display("FAIL %s bit%0d cyc%0d: txd=%b busy=%b expected txd=%b busy=1",
                             name, b, c, txd_of(sel), busy_of(sel), exp_bits[b]);
                end
            end
        end
        for (int i = 0; i < DATA_W; i++) rx_data[i] = rx_bits[i+1];
        checks++;
        if (rx_data !== d || rx_bits[DATA_W+1] !== ((osel ? ~^rx_data : ^rx_data) ^ inj)
            || rx_bits[DATA_W+2] !== 1'b1) begin
            errors++;
            $display("FAIL %s loopback: rx_data=%b par=%b stop=%b expected data=%b par=%b stop=1",
                     name, rx_data, rx_bits[DATA_W+1], rx_bits[DATA_W+2], d,
                     (osel ? exp_odd : exp_even) ^ inj);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_of(sel) !== 1'b0 || ready_of(sel) !== 1'b1 || txd_of(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_gap: busy=%b ready=%b txd=%b expected 0 1 1",
                     name, busy_of(sel), ready_of(sel), txd_of(sel));
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (txd_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || even_a !== 1'b0 || odd_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: txd=%b ready=%b busy=%b even=%b odd=%b expected 1 1 0 0 1",
                     txd_a, ready_a, busy_a, even_a, odd_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame();
        send(0, 4'b1011, 1'b0, 1'b0);
        check_frame(0, 4'b1011, 1'b0, 1'b0, "frame_1011");
    endtask

    task automatic test_parity_select();
        send(0, 4'b0000, 1'b0, 1'b0);
        check_frame(0, 4'b0000, 1'b0, 1'b0, "sel_0000_even");
        send(0, 4'b0000, 1'b1, 1'b0);
        check_frame(0, 4'b0000, 1'b1, 1'b0, "sel_0000_odd");
        send(0, 4'b1111, 1'b1, 1'b0);
        check_frame(0, 4'b1111, 1'b1, 1'b0, "sel_1111_odd");
    endtask

    task automatic test_busy_ignore();
        data_a = 4'b0101; odd_sel_a = 1'b0; valid_a = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NBITS * 4; i++) begin
            @(negedge clk);
            checks++;
            if (txd_a !== ((i < 4) ? 1'b0 : (i < 20) ? 4'b0101 >> ((i - 4) / 4) & 1'b1 :
                           (i < 24) ? 1'b0 : 1'b1) || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL busy_ignore cyc%0d: txd=%b busy=%b", i, txd_a, busy_a);
            end
            data_a = 4'(i * 5 + 3);
            odd_sel_a = i[0];
        end
        data_a = 4'b1100; odd_sel_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_gap: ready=%b busy=%b expected 1 0", ready_a, busy_a);
        end
        @(posedge clk); #1;
        valid_a = 1'b0;
        check_frame(0, 4'b1100, 1'b1, 1'b0, "busy_ignore_next");
    endtask

    task automatic test_reset_mid_frame();
        send(0, 4'b1011, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (txd_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || even_a !== 1'b0 || odd_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_frame: txd=%b ready=%b busy=%b even=%b odd=%b expected 1 1 0 0 1",
                     txd_a, ready_a, busy_a, even_a, odd_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_resume cyc%0d: txd=%b busy=%b expected 1 0", i, txd_a, busy_a);
            end
        end
        @(posedge clk); #1;
        send(0, 4'b0110, 1'b0, 1'b0);
        check_frame(0, 4'b0110, 1'b0, 1'b0, "after_reset_0110");
    endtask

    task automatic test_sweep();
        for (int sel = 0; sel < 2; sel++) begin
            for (int v = 0; v < 32; v++) begin
                logic [4:0] vv = 5'(v);
                send(sel, vv[3:0], vv[4], 1'b0);
                check_frame(sel, vv[3:0], vv[4], 1'b0, (sel != 0) ? "sweep_cpb1" : "sweep_cpb4");
            end
        end
    endtask

`ifdef PAR_TX_ERR_INJ_EN
    task automatic test_err_inj();
        send(0, 4'b0001, 1'b0, 1'b1);
        check_frame(0, 4'b0001, 1'b0, 1'b1, "err_inj_0001");
        send(0, 4'b0001, 1'b0, 1'b0);
        check_frame(0, 4'b0001, 1'b0, 1'b0, "err_inj_off_0001");
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_parity_select();
        test_busy_ignore();
        test_reset_mid_frame();
        test_sweep();
`ifdef PAR_TX_ERR_INJ_EN
        test_err_inj();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
